// File: rtl/seg_scan_ctrl.sv
// Scan controller for the 8-digit common-anode seven-segment display: prescaled digit scan,
// frame-synchronous double-buffered updates. Define SEG_SCAN_LZ_BLANK_EN for leading-zero suppression.

module decoder3to8 (
  input  logic [2:0] a,
  output logic [7:0] y
);
  assign y = ~(8'b0000_0001 << a);
endmodule

module seg_scan_ctrl #(
  parameter int DIV   = 100000,
  parameter int BLANK = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] data,
  input  logic [7:0]  digit_en,
  input  logic [7:0]  dp,
  input  logic        upd_req,
  output logic        upd_ack,
  output logic [2:0]  num,
  output logic [7:0]  sel,
  output logic [7:0]  seg,
  output logic        frame_done
);

  localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(DIV - 1);

  function automatic logic [6:0] hex7(input logic [3:0] n);
    logic [6:0] s;
    case (n)
      4'h0: s = 7'h40;
      4'h1: s = 7'h79;
      4'h2: s = 7'h24;
      4'h3: s = 7'h30;
      4'h4: s = 7'h19;
      4'h5: s = 7'h12;
      4'h6: s = 7'h02;
      4'h7: s = 7'h78;
      4'h8: s = 7'h00;
      4'h9: s = 7'h10;
      4'hA: s = 7'h08;
      4'hB: s = 7'h03;
      4'hC: s = 7'h46;
      4'hD: s = 7'h21;
      4'hE: s = 7'h06;
      default: s = 7'h0E;
    endcase
    return s;
  endfunction

  logic [CW-1:0] div_cnt;
  logic [2:0]    idx;
  logic          tick;
  logic          boundary;

  // shadow (_p0, valid = pending) and active (_p1) display contents
  logic [31:0] data_p0, data_p1;
  logic [7:0]  en_p0, en_p1;
  logic [7:0]  dp_p0, dp_p1;
  logic        vld_p0;

  assign tick     = (div_cnt == LAST);
  assign boundary = tick && (idx == 3'd7);

  always_ff @(posedge clk) begin
    if (rst) begin
      div_cnt    <= '0;
      idx        <= '0;
      frame_done <= 1'b0;
      upd_ack    <= 1'b0;
      vld_p0     <= 1'b0;
      data_p1    <= '0;
      en_p1      <= '0;
      dp_p1      <= '0;
    end else begin
      div_cnt    <= tick ? '0 : div_cnt + 1'b1;
      if (tick) idx <= idx + 3'd1;
      frame_done <= boundary;
      upd_ack    <= boundary && (upd_req || vld_p0);
      if (boundary) begin
        vld_p0 <= 1'b0;
        // a request landing on the boundary itself skips the shadow
        if (upd_req) begin
          data_p1 <= data;
          en_p1   <= digit_en;
          dp_p1   <= dp;
        end else if (vld_p0) begin
          data_p1 <= data_p0;
          en_p1   <= en_p0;
          dp_p1   <= dp_p0;
        end
      end else if (upd_req) begin
        vld_p0 <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (upd_req && !boundary) begin
      data_p0 <= data;
      en_p0   <= digit_en;
      dp_p0   <= dp;
    end
  end

  // output decode from registered state, no added latency
  logic [3:0] nib;
  logic [7:0] dec_sel;
  logic       in_blank;
  logic       lz_sup;
  logic       blank;

  decoder3to8 u_dec (
    .a (idx),
    .y (dec_sel)
  );

  assign nib = data_p1[{idx, 2'b00} +: 4];

  if (BLANK == 0) begin : g_noblank
    assign in_blank = 1'b0;
  end else begin : g_blank
    assign in_blank = (div_cnt < CW'(BLANK));
  end

`ifdef SEG_SCAN_LZ_BLANK_EN
  logic [7:0] lz_mask;
  logic       lz_seen;

  // digit i is suppressed while every nibble from 7 down to i is zero; digit 0 always shows
  always_comb begin
    lz_mask = 8'h00;
    lz_seen = 1'b0;
    for (int i = 7; i >= 1; i--) begin
      lz_seen    = lz_seen | (data_p1[4*i +: 4] != 4'h0);
      lz_mask[i] = ~lz_seen;
    end
  end

  assign lz_sup = lz_mask[idx];
`else
  assign lz_sup = 1'b0;
`endif

  assign blank = in_blank || !en_p1[idx] || lz_sup;
  assign sel   = blank ? 8'hFF : dec_sel;
  assign seg   = blank ? 8'hFF : {~dp_p1[idx], hex7(nib)};
  assign num   = idx;

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Directed bench for seg_scan_ctrl at DIV=4, BLANK=1; outputs sampled on the falling edge.
`timescale 1ns/1ps

module tb_seg_scan_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] data = '0;
  logic [7:0]  digit_en = '0;
  logic [7:0]  dp = '0;
  logic        upd_req = 1'b0;
  logic        upd_ack;
  logic [2:0]  num;
  logic [7:0]  sel;
  logic [7:0]  seg;
  logic        frame_done;

  int n_chk  = 0;
  int n_pass = 0;
  int t      = 0;
  int acks   = 0;

  seg_scan_ctrl #(.DIV(4), .BLANK(1)) dut (
    .clk        (clk),
    .rst        (rst),
    .data       (data),
    .digit_en   (digit_en),
    .dp         (dp),
    .upd_req    (upd_req),
    .upd_ack    (upd_ack),
    .num        (num),
    .sel        (sel),
    .seg        (seg),
    .frame_done (frame_done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h (t=%0d)", tag, obs, exp, t);
  endtask

  task automatic adv(input int n);
    repeat (n) begin
      @(negedge clk);
      t++;
    end
  endtask

  task automatic go(input int target);
    if (target > t) adv(target - t);
  endtask

  task automatic req(input logic [31:0] d, input logic [7:0] e, input logic [7:0] p);
    data     = d;
    digit_en = e;
    dp       = p;
    upd_req  = 1'b1;
    adv(1);
    upd_req  = 1'b0;
  endtask

  logic [7:0] seg305 [8] = '{8'h92, 8'hC0, 8'hB0, 8'hC0, 8'hC0, 8'hC0, 8'hC0, 8'hC0};
  logic [7:0] seg000 [8] = '{8'h40, 8'hC0, 8'hC0, 8'hC0, 8'hC0, 8'hC0, 8'hC0, 8'hC0};
  logic [7:0] segf0  [8] = '{8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'h03, 8'h08, 8'h10, 8'h00};

  initial begin
    logic [7:0] es;
    logic [7:0] eg;
    int slot;
    int c;

    repeat (3) @(negedge clk);
    chk("rst_num", num, 0);
    chk("rst_sel", sel, 8'hFF);
    chk("rst_seg", seg, 8'hFF);
    chk("rst_ack", upd_ack, 0);
    chk("rst_fd", frame_done, 0);
    rst = 1'b0;
    t   = 0;

    // first frame: nothing enabled, index steps every 4 cycles
    for (int k = 0; k < 32; k++) begin
      go(k);
      chk("f0_num", num, (k / 4) % 8);
      chk("f0_sel", sel, 8'hFF);
      chk("f0_seg", seg, 8'hFF);
      chk("f0_fd", frame_done, 0);
    end
    go(32);
    chk("f0_fd_wrap", frame_done, 1);
    chk("f0_num_wrap", num, 0);
    go(33);
    chk("f0_fd_pulse", frame_done, 0);

    // mid-frame update held until boundary
    go(42);
    req(32'h76543210, 8'hFF, 8'h01);
    chk("mid_sel_hold", sel, 8'hFF);
    chk("mid_ack_hold", upd_ack, 0);
    go(63);
    chk("mid_sel_end", sel, 8'hFF);
    chk("mid_ack_end", upd_ack, 0);
    chk("mid_num_end", num, 7);
    go(64);
    chk("mid_ack", upd_ack, 1);
    chk("mid_fd", frame_done, 1);
    chk("mid_blank_sel", sel, 8'hFF);
    chk("mid_blank_seg", seg, 8'hFF);
    go(65);
    chk("s0_sel", sel, 8'hFE);
    chk("s0_seg", seg, 8'h40);
    chk("mid_ack_pulse", upd_ack, 0);
    go(67);
    chk("s0_sel_c3", sel, 8'hFE);
    chk("s0_seg_c3", seg, 8'h40);
    go(68);
    chk("s1_blank", sel, 8'hFF);
    go(69);
    chk("s1_sel", sel, 8'hFD);
    chk("s1_seg", seg, 8'hF9);
    go(93);
    chk("s7_sel", sel, 8'h7F);
    chk("s7_seg", seg, 8'hF8);

    // two requests in one frame: last wins, one ack
    go(100);
    req(32'h11111111, 8'hFF, 8'h00);
    acks = 0;
    go(110);
    req(32'h22222222, 8'hFF, 8'h00);
    for (int k = 111; k < 160; k++) begin
      go(k);
      acks += int'(upd_ack);
      if (k == 128) begin
        chk("dbl_ack", upd_ack, 1);
        chk("dbl_fd", frame_done, 1);
      end
      if (k > 128 && ((k - 128) % 4) != 0) begin
        slot = (k - 128) / 4;
        es   = ~(8'h01 << slot);
        chk("dbl_sel", sel, es);
        chk("dbl_seg", seg, 8'hA4);
      end
    end
    chk("dbl_ack_count", acks, 1);

    // request on the boundary tick bypasses the shadow; also digit_en=F0
    chk("byp_num_pre", num, 7);
    req(32'h89ABCDEF, 8'hF0, 8'hF0);
    chk("byp_ack", upd_ack, 1);
    chk("byp_fd", frame_done, 1);
    for (int k = 161; k < 192; k++) begin
      go(k);
      slot = (k - 160) / 4;
      c    = (k - 160) % 4;
      es   = (c == 0 || slot < 4) ? 8'hFF : ~(8'h01 << slot);
      eg   = (c == 0) ? 8'hFF : segf0[slot];
      chk("en_sel", sel, es);
      chk("en_seg", seg, eg);
      if (k == 161) chk("byp_ack_pulse", upd_ack, 0);
    end

    // reset mid-frame with a pending update discards it
    req(32'h12345678, 8'hFF, 8'hFF);
    go(194);
    rst = 1'b1;
    adv(1);
    rst = 1'b0;
    t   = 0;
    chk("mrst_num", num, 0);
    chk("mrst_sel", sel, 8'hFF);
    chk("mrst_seg", seg, 8'hFF);
    chk("mrst_ack", upd_ack, 0);
    go(5);
    chk("mrst_sel_s1", sel, 8'hFF);
    go(29);
    chk("mrst_sel_s7", sel, 8'hFF);
    go(32);
    chk("mrst_fd", frame_done, 1);
    chk("mrst_no_ack", upd_ack, 0);
    go(33);
    chk("mrst_sel_after", sel, 8'hFF);

    // leading zeros: 0x00000305
    go(40);
    req(32'h00000305, 8'hFF, 8'h00);
    go(64);
    chk("lz_ack", upd_ack, 1);
    for (int s = 0; s < 8; s++) begin
      go(65 + 4 * s);
      es = ~(8'h01 << s);
      eg = seg305[s];
`ifdef SEG_SCAN_LZ_BLANK_EN
      if (s >= 3) begin
        es = 8'hFF;
        eg = 8'hFF;
      end
`endif
      chk("lz305_sel", sel, es);
      chk("lz305_seg", seg, eg);
    end

    // all-zero value, dp on digit 0 only
    go(80);
    req(32'h00000000, 8'hFF, 8'h01);
    go(96);
    chk("lz0_ack", upd_ack, 1);
    for (int s = 0; s < 8; s++) begin
      go(97 + 4 * s);
      es = ~(8'h01 << s);
      eg = seg000[s];
`ifdef SEG_SCAN_LZ_BLANK_EN
      if (s >= 1) begin
        es = 8'hFF;
        eg = 8'hFF;
      end
`endif
      chk("lz0_sel", sel, es);
      chk("lz0_seg", seg, eg);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL watchdog: simulation time limit reached, observed t=%0d", t);
    $fatal(1, "watchdog expired");
  end

endmodule
